// File: rtl/psola_pkg.sv
// rtl/psola_pkg.sv - shared types and defaults for the psola frame sequencer
package psola_pkg;

   typedef enum logic [2:0] {IDLE, CLEAR, START, RUN, DONE} seq_state_t;

   typedef logic [10:0] tau_t;
   typedef logic [11:0] len_t;

   localparam int unsigned MIN_TAU_DEF = 20;
   localparam int unsigned MAX_TAU_DEF = 1023;
   localparam int unsigned CAP_IDX_FIELD_W = 11;

   // Saturate a reported window length to the depth of one output bank
   function automatic len_t clamp_len(input len_t len, input int unsigned max_len);
      return (len > len_t'(max_len)) ? len_t'(max_len) : len;
   endfunction

endpackage

// File: rtl/psola_capture_ctrl.sv
// rtl/psola_capture_ctrl.sv - ping-pong capture counter with bank swap and overrun flag
module psola_capture_ctrl
   import psola_pkg::*;
#(
   parameter int unsigned WINDOW_SIZE = 2048
)
(
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        sample_valid_in,
   input  logic [15:0] sample_in,
   input  logic        swap_ok_in,
   output logic        cap_wr_en_out,
   output logic [11:0] cap_wr_addr_out,
   output logic [15:0] cap_wr_data_out,
   output logic        cap_bank_out,
   output logic        frame_go_set_out,
   output logic        overrun_out
);

   localparam int unsigned IDX_W = $clog2(WINDOW_SIZE);

   logic [IDX_W-1:0] cap_idx;
   logic             wrap;

   // Last index of a window is all ones because WINDOW_SIZE is a power of two
   assign wrap             = sample_valid_in && (&cap_idx);
   assign frame_go_set_out = wrap && swap_ok_in;

   // Write port is driven in the same cycle the sample arrives
   assign cap_wr_en_out   = sample_valid_in;
   assign cap_wr_addr_out = {cap_bank_out, CAP_IDX_FIELD_W'(cap_idx)};
   assign cap_wr_data_out = sample_valid_in ? sample_in : 16'd0;

   // Advance the write index; swap banks on a full window only when the sequencer can take it
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cap_idx      <= '0;
         cap_bank_out <= 1'b0;
         overrun_out  <= 1'b0;
      end else if (sample_valid_in) begin
         cap_idx <= cap_idx + 1'b1;
         if (wrap) begin
            if (swap_ok_in) begin
               cap_bank_out <= ~cap_bank_out;
            end else begin
               overrun_out <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/psola_frame_sequencer.sv
// rtl/psola_frame_sequencer.sv - frame-level controller launching one psola pass per window
module psola_frame_sequencer
   import psola_pkg::*;
#(
   parameter int unsigned WINDOW_SIZE    = 2048,
   parameter int unsigned MAX_EXTENDED   = 2200,
   parameter int unsigned MIN_TAU        = MIN_TAU_DEF,
   parameter int unsigned MAX_TAU        = MAX_TAU_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 65536
)
(
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        sample_valid_in,
   input  logic [15:0] sample_in,
   input  logic        tau_valid_in,
   input  logic [10:0] tau_in,
   output logic        cap_wr_en_out,
   output logic [11:0] cap_wr_addr_out,
   output logic [15:0] cap_wr_data_out,
   output logic        psola_bank_out,
   output logic        psola_tau_valid_out,
   output logic [10:0] psola_tau_out,
   input  logic        psola_len_valid_in,
   input  logic [11:0] psola_len_in,
   output logic        clr_en_out,
   output logic [11:0] clr_addr_out,
   output logic        acc_bank_out,
   output logic        frame_valid_out,
   output logic        frame_bank_out,
   output logic [11:0] frame_len_out,
   output logic        overrun_out,
   output logic        timeout_out,
   output logic        busy_out
);

   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam len_t            CLR_LAST = len_t'(MAX_EXTENDED - 1);
   localparam tau_t            TAU_LO   = tau_t'(MIN_TAU);
   localparam tau_t            TAU_HI   = tau_t'(MAX_TAU);

   seq_state_t      state;
   tau_t            tau_lat;
   logic            tau_have;
   logic            frame_go;
   logic [WD_W-1:0] watchdog;
   logic            cap_bank;
   logic            frame_go_set;
   logic            accept;
   logic            swap_ok;

   // A wrap landing on the accept cycle counts as busy so the bank psola is about to read stays put
   assign accept  = (state == IDLE) && frame_go && tau_have;
   assign swap_ok = (state == IDLE) && !accept;

   psola_capture_ctrl #(
      .WINDOW_SIZE (WINDOW_SIZE)
   ) u_capture (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .sample_valid_in  (sample_valid_in),
      .sample_in        (sample_in),
      .swap_ok_in       (swap_ok),
      .cap_wr_en_out    (cap_wr_en_out),
      .cap_wr_addr_out  (cap_wr_addr_out),
      .cap_wr_data_out  (cap_wr_data_out),
      .cap_bank_out     (cap_bank),
      .frame_go_set_out (frame_go_set),
      .overrun_out      (overrun_out)
   );

   // Hold the most recent in-range pitch period; out-of-range reports are dropped
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         tau_lat  <= '0;
         tau_have <= 1'b0;
      end else if (tau_valid_in && (tau_in >= TAU_LO) && (tau_in <= TAU_HI)) begin
         tau_lat  <= tau_in;
         tau_have <= 1'b1;
      end
   end

   // Frame FSM: clear output bank, pulse psola, wait for length or watchdog, publish and swap
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state               <= IDLE;
         frame_go            <= 1'b0;
         watchdog            <= '0;
         psola_bank_out      <= 1'b0;
         psola_tau_valid_out <= 1'b0;
         psola_tau_out       <= '0;
         clr_en_out          <= 1'b0;
         clr_addr_out        <= '0;
         acc_bank_out        <= 1'b0;
         frame_valid_out     <= 1'b0;
         frame_bank_out      <= 1'b0;
         frame_len_out       <= '0;
         timeout_out         <= 1'b0;
         busy_out            <= 1'b0;
      end else begin
         psola_tau_valid_out <= 1'b0;
         frame_valid_out     <= 1'b0;
         if (frame_go_set) begin
            frame_go <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (accept) begin
                  state          <= CLEAR;
                  frame_go       <= 1'b0;
                  busy_out       <= 1'b1;
                  psola_bank_out <= ~cap_bank;
                  psola_tau_out  <= tau_lat;
                  clr_en_out     <= 1'b1;
                  clr_addr_out   <= '0;
               end
            end
            CLEAR: begin
               if (clr_addr_out == CLR_LAST) begin
                  clr_en_out   <= 1'b0;
                  clr_addr_out <= '0;
                  state        <= START;
               end else begin
                  clr_addr_out <= clr_addr_out + 1'b1;
               end
            end
            START: begin
               psola_tau_valid_out <= 1'b1;
               watchdog            <= '0;
               state               <= RUN;
            end
            RUN: begin
               if (psola_len_valid_in) begin
                  frame_len_out <= clamp_len(psola_len_in, MAX_EXTENDED);
                  state         <= DONE;
               end else if (watchdog == WD_LAST) begin
                  timeout_out   <= 1'b1;
                  frame_len_out <= '0;
                  state         <= DONE;
               end else begin
                  watchdog <= watchdog + 1'b1;
               end
            end
            DONE: begin
               frame_valid_out <= 1'b1;
               frame_bank_out  <= acc_bank_out;
               acc_bank_out    <= ~acc_bank_out;
               busy_out        <= 1'b0;
               state           <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psola_frame_sequencer.sv
// tb/tb_psola_frame_sequencer.sv - directed self-checking bench for psola_frame_sequencer
module tb_psola_frame_sequencer;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        sample_valid_in = 1'b0;
   logic [15:0] sample_in = '0;
   logic        tau_valid_in = 1'b0;
   logic [10:0] tau_in = '0;
   logic        cap_wr_en_out;
   logic [11:0] cap_wr_addr_out;
   logic [15:0] cap_wr_data_out;
   logic        psola_bank_out;
   logic        psola_tau_valid_out;
   logic [10:0] psola_tau_out;
   logic        psola_len_valid_in = 1'b0;
   logic [11:0] psola_len_in = '0;
   logic        clr_en_out;
   logic [11:0] clr_addr_out;
   logic        acc_bank_out;
   logic        frame_valid_out;
   logic        frame_bank_out;
   logic [11:0] frame_len_out;
   logic        overrun_out;
   logic        timeout_out;
   logic        busy_out;

   int total = 0;
   int bad   = 0;

   psola_frame_sequencer #(
      .WINDOW_SIZE    (16),
      .MAX_EXTENDED   (20),
      .MIN_TAU        (4),
      .MAX_TAU        (7),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk_in              (clk_in),
      .rst_in              (rst_in),
      .sample_valid_in     (sample_valid_in),
      .sample_in           (sample_in),
      .tau_valid_in        (tau_valid_in),
      .tau_in              (tau_in),
      .cap_wr_en_out       (cap_wr_en_out),
      .cap_wr_addr_out     (cap_wr_addr_out),
      .cap_wr_data_out     (cap_wr_data_out),
      .psola_bank_out      (psola_bank_out),
      .psola_tau_valid_out (psola_tau_valid_out),
      .psola_tau_out       (psola_tau_out),
      .psola_len_valid_in  (psola_len_valid_in),
      .psola_len_in        (psola_len_in),
      .clr_en_out          (clr_en_out),
      .clr_addr_out        (clr_addr_out),
      .acc_bank_out        (acc_bank_out),
      .frame_valid_out     (frame_valid_out),
      .frame_bank_out      (frame_bank_out),
      .frame_len_out       (frame_len_out),
      .overrun_out         (overrun_out),
      .timeout_out         (timeout_out),
      .busy_out            (busy_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},      32'(busy_out), 0);
      check({tag, "_clr_en"},    32'(clr_en_out), 0);
      check({tag, "_clr_addr"},  32'(clr_addr_out), 0);
      check({tag, "_ptau_v"},    32'(psola_tau_valid_out), 0);
      check({tag, "_ptau"},      32'(psola_tau_out), 0);
      check({tag, "_pbank"},     32'(psola_bank_out), 0);
      check({tag, "_acc_bank"},  32'(acc_bank_out), 0);
      check({tag, "_fvalid"},    32'(frame_valid_out), 0);
      check({tag, "_fbank"},     32'(frame_bank_out), 0);
      check({tag, "_flen"},      32'(frame_len_out), 0);
      check({tag, "_overrun"},   32'(overrun_out), 0);
      check({tag, "_timeout"},   32'(timeout_out), 0);
      check({tag, "_cap_addr"},  32'(cap_wr_addr_out), 0);
      check({tag, "_cap_en"},    32'(cap_wr_en_out), 0);
   endtask

   task automatic pulse_tau(input logic [10:0] t);
      tau_valid_in = 1'b1;
      tau_in       = t;
      @(negedge clk_in);
      tau_valid_in = 1'b0;
   endtask

   // Feed n samples starting at index 0 of the given bank, optionally checking the write port
   task automatic send_window(input int n, input logic bank, input bit chk);
      for (int i = 0; i < n; i++) begin
         sample_valid_in = 1'b1;
         sample_in       = 16'(16'h1000 + i);
         #1;
         if (chk) begin
            check("cap_en",   32'(cap_wr_en_out), 1);
            check("cap_addr", 32'(cap_wr_addr_out), 32'({bank, 11'(i)}));
            check("cap_data", 32'(cap_wr_data_out), 32'(16'h1000 + i));
         end
         @(negedge clk_in);
      end
      sample_valid_in = 1'b0;
      sample_in       = '0;
   endtask

   // Follow CLEAR through START; returns at the negedge where the psola pulse is visible
   task automatic follow_clear(input logic [10:0] exp_tau, input logic exp_pbank);
      int k;
      int n;
      k = 0;
      while (!clr_en_out && k < 10) begin
         @(negedge clk_in);
         k++;
      end
      check("clr_start", 32'(clr_en_out), 1);
      check("clr_tau",   32'(psola_tau_out), 32'(exp_tau));
      check("clr_pbank", 32'(psola_bank_out), 32'(exp_pbank));
      n = 0;
      while (clr_en_out && n < 40) begin
         check("clr_addr", 32'(clr_addr_out), 32'(n));
         check("clr_no_pulse", 32'(psola_tau_valid_out), 0);
         @(negedge clk_in);
         n++;
      end
      check("clr_count", 32'(n), 20);
      check("start_no_pulse", 32'(psola_tau_valid_out), 0);
      check("start_busy", 32'(busy_out), 1);
      @(negedge clk_in);
      check("pulse", 32'(psola_tau_valid_out), 1);
      check("pulse_tau", 32'(psola_tau_out), 32'(exp_tau));
      check("pulse_pbank", 32'(psola_bank_out), 32'(exp_pbank));
   endtask

   // Wait for the published frame and check its fields, then check the pulse is one cycle wide
   task automatic expect_frame(input int exp_wait, input logic [11:0] exp_len,
                               input logic exp_fbank, input logic exp_acc);
      int k;
      k = 0;
      while (!frame_valid_out && k < 200) begin
         @(negedge clk_in);
         k++;
      end
      check("frame_wait", 32'(k), 32'(exp_wait));
      check("frame_valid", 32'(frame_valid_out), 1);
      check("frame_len", 32'(frame_len_out), 32'(exp_len));
      check("frame_bank", 32'(frame_bank_out), 32'(exp_fbank));
      check("acc_bank", 32'(acc_bank_out), 32'(exp_acc));
      check("frame_idle", 32'(busy_out), 0);
      @(negedge clk_in);
      check("frame_pulse_end", 32'(frame_valid_out), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed=stuck expected=finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      int pulses;

      repeat (3) @(negedge clk_in);
      check_all_zero("rst");
      rst_in = 1'b0;
      @(negedge clk_in);

      // Frame 1: tau=5, capture bank 0, psola reads bank 0, accumulates into bank 0
      pulse_tau(11'd5);
      send_window(16, 1'b0, 1'b1);
      check("bank_swap1", 32'(cap_wr_addr_out), 32'h800);
      follow_clear(11'd5, 1'b0);
      psola_len_valid_in = 1'b1;
      psola_len_in       = 12'd18;
      @(negedge clk_in);
      psola_len_valid_in = 1'b0;
      expect_frame(1, 12'd18, 1'b0, 1'b1);

      // Stray length strobe while idle is ignored
      psola_len_valid_in = 1'b1;
      psola_len_in       = 12'd9;
      @(negedge clk_in);
      psola_len_valid_in = 1'b0;
      @(negedge clk_in);
      check("idle_len_fvalid", 32'(frame_valid_out), 0);
      check("idle_len_busy", 32'(busy_out), 0);
      check("idle_len_flen", 32'(frame_len_out), 18);

      // Frame 2: out-of-range taus dropped, tau 5 kept; overrun during RUN; length clamps to 20
      pulse_tau(11'd3);
      pulse_tau(11'd2000);
      send_window(16, 1'b1, 1'b0);
      check("bank_swap2", 32'(cap_wr_addr_out), 32'h000);
      follow_clear(11'd5, 1'b1);
      check("overrun_pre", 32'(overrun_out), 0);
      send_window(16, 1'b0, 1'b0);
      check("overrun_set", 32'(overrun_out), 1);
      check("overrun_nobank", 32'(cap_wr_addr_out), 32'h000);
      check("overrun_busy", 32'(busy_out), 1);
      psola_len_valid_in = 1'b1;
      psola_len_in       = 12'd25;
      @(negedge clk_in);
      psola_len_valid_in = 1'b0;
      expect_frame(1, 12'd20, 1'b1, 1'b0);
      check("overrun_sticky", 32'(overrun_out), 1);

      // Frame 3: psola never answers, watchdog fires after 64 RUN cycles
      send_window(16, 1'b0, 1'b0);
      check("bank_swap3", 32'(cap_wr_addr_out), 32'h800);
      follow_clear(11'd5, 1'b0);
      check("timeout_pre", 32'(timeout_out), 0);
      expect_frame(65, 12'd0, 1'b0, 1'b1);
      check("timeout_set", 32'(timeout_out), 1);
      repeat (3) @(negedge clk_in);
      check("timeout_sticky", 32'(timeout_out), 1);

      // Fresh start without tau: frame waits until a valid tau arrives
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      check_all_zero("rst2");
      send_window(16, 1'b0, 1'b0);
      repeat (5) @(negedge clk_in);
      check("notau_busy", 32'(busy_out), 0);
      check("notau_clr", 32'(clr_en_out), 0);
      check("notau_bank", 32'(cap_wr_addr_out), 32'h800);
      pulse_tau(11'd7);
      check("tau7_not_yet", 32'(busy_out), 0);
      @(negedge clk_in);
      check("tau7_busy", 32'(busy_out), 1);
      check("tau7_clr_en", 32'(clr_en_out), 1);
      check("tau7_clr_addr", 32'(clr_addr_out), 0);
      check("tau7_ptau", 32'(psola_tau_out), 7);

      // Reset in the middle of CLEAR aborts with no psola pulse afterwards
      @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
      check_all_zero("rst_mid");
      rst_in = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_in);
         if (psola_tau_valid_out) pulses++;
      end
      check("rst_no_pulse", 32'(pulses), 0);
      check("rst_idle", 32'(busy_out), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
